// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared FSM encoding and constants for the instruction memory loader
package instr_mem_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] WE_ALL = 4'hF;
  localparam int DEFAULT_MAX_WORDS = 1024;
  function automatic logic [31:0] clamp_count(input logic [31:0] wc, input logic [31:0] max);
    return wc > max ? max : wc;
  endfunction
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream handshake plus instruction RAM write port
interface instr_mem_loader_if;
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic mem_en;
  logic [3:0] mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  modport master (output byte_in, byte_valid, input byte_ready, mem_en, mem_we, mem_addr, mem_din);
  modport slave (input byte_in, byte_valid, output byte_ready, mem_en, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a byte stream big-endian into words and writes them to instruction RAM
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [31:0] word_count,
  instr_mem_loader_if.slave bus,
  output logic busy,
  output logic cpu_hold,
  output logic done,
  output logic [7:0] checksum
);
  state_t state, state_n;
  logic [31:0] count, count_n, idx, idx_n, word, word_n;
  logic [1:0] bcnt, bcnt_n;
  logic [7:0] csum_n;
  logic take, go;
  assign bus.mem_addr = idx;
  assign bus.mem_din = word;
  // next state and datapath: start from IDLE/DONE, byte intake in RECV, index advance out of WRITE
  always_comb begin
    take = state == RECV && bus.byte_valid && bus.byte_ready;
    go = (state == IDLE || state == DONE) && start;
    state_n = state;
    count_n = count;
    idx_n = idx;
    bcnt_n = bcnt;
    word_n = word;
    csum_n = checksum;
    if (go) begin
      count_n = clamp_count(word_count, 32'(MAX_WORDS));
      idx_n = '0;
      bcnt_n = '0;
      csum_n = '0;
      state_n = count_n == '0 ? DONE : RECV;
    end
    if (take) begin
      word_n = {word[23:0], bus.byte_in};
      csum_n = checksum ^ bus.byte_in;
      bcnt_n = bcnt + 2'd1;
      state_n = bcnt == 2'd3 ? WRITE : RECV;
    end
    if (state == WRITE) begin
      idx_n = idx + 32'd1;
      state_n = idx_n == count ? DONE : RECV;
    end
  end
  // state/datapath registers; outputs are decoded from the next state so they are flop-driven
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      idx <= '0;
      bcnt <= '0;
      word <= '0;
      checksum <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 4'h0;
      busy <= 1'b0;
      done <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state <= state_n;
      count <= count_n;
      idx <= idx_n;
      bcnt <= bcnt_n;
      word <= word_n;
      checksum <= csum_n;
      bus.byte_ready <= state_n == RECV;
      bus.mem_en <= state_n == WRITE;
      bus.mem_we <= state_n == WRITE ? WE_ALL : 4'h0;
      busy <= state_n == RECV || state_n == WRITE;
      done <= state_n == DONE;
      cpu_hold <= state_n != DONE;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized load scenarios checked against a byte-queue model
module tb_instr_mem_loader;
  localparam int MAXW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] word_count = '0;
  logic busy, cpu_hold, done;
  logic [7:0] checksum;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sent[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  instr_mem_loader_if bus ();
  instr_mem_loader #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .bus(bus),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
  );
  always #5 clk = ~clk;
  // record every write strobe seen mid-cycle, as the RAM would capture it
  always @(negedge clk) begin
    if (bus.mem_we == 4'hF) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_din);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model_csum();
    logic [7:0] x = '0;
    foreach (sent[i]) x ^= sent[i];
    return x;
  endfunction
  task automatic do_start(input logic [31:0] wc);
    start = 1'b1;
    word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
    sent.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask
  task automatic push(input logic [7:0] b, input bit gaps);
    int g = 0;
    if (gaps) begin
      bus.byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    if (g >= 100) chk("handshake_timeout", 32'(g), 32'd0);
    else sent.push_back(b);
  endtask
  task automatic wait_done();
    int g = 0;
    while (!done && g < 50) begin @(posedge clk); #1; g++; end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask
  task automatic check_writes(input int n);
    chk("write_count", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk($sformatf("addr[%0d]", i), wr_addr[i], 32'(i));
      chk($sformatf("data[%0d]", i), wr_data[i], {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]});
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] prog[8];
    prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_checksum", {24'd0, checksum}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
    do_start(32'd2);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, bus.byte_ready}, 32'd1);
    chk("start_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 8; i++) push(prog[i], 1'b0);
    chk("w1_we", {28'd0, bus.mem_we}, 32'hF);
    chk("w1_en", {31'd0, bus.mem_en}, 32'd1);
    chk("w1_addr", bus.mem_addr, 32'd1);
    chk("w1_din", bus.mem_din, 32'h9ABCDEF0);
    chk("w1_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("w1_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("p2_done", {31'd0, done}, 32'd1);
    chk("p2_hold", {31'd0, cpu_hold}, 32'd0);
    chk("p2_we", {28'd0, bus.mem_we}, 32'd0);
    chk("p2_busy", {31'd0, busy}, 32'd0);
    chk("p2_checksum", {24'd0, checksum}, {24'd0, model_csum()});
    check_writes(2);
    chk("p2_word0", wr_data.size() > 0 ? wr_data[0] : 32'hX, 32'h12345678);
    do_start(32'd3);
    for (int i = 0; i < 12; i++) push(8'($urandom), 1'b1);
    wait_done();
    check_writes(3);
    chk("rand_checksum", {24'd0, checksum}, {24'd0, model_csum()});
    do_start(32'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("zero_checksum", {24'd0, checksum}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("zero_writes", 32'(wr_addr.size()), 32'd0);
    do_start(32'(MAXW + 5));
    chk("clamp_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 4 * MAXW; i++) push(8'($urandom), 1'b0);
    wait_done();
    check_writes(MAXW);
    chk("clamp_last_addr", wr_addr.size() > 0 ? wr_addr[$] : 32'hX, 32'(MAXW - 1));
    bus.byte_in = 8'hAA;
    bus.byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("clamp_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("clamp_checksum", {24'd0, checksum}, {24'd0, model_csum()});
    chk("clamp_no_extra", 32'(wr_addr.size()), 32'(MAXW));
    bus.byte_valid = 1'b0;
    do_start(32'd2);
    for (int i = 0; i < 6; i++) push(8'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_checksum", {24'd0, checksum}, 32'd0);
    chk("mid_rst_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_en", {31'd0, bus.mem_en}, 32'd0);
    do_start(32'd1);
    for (int i = 0; i < 4; i++) push(8'($urandom), 1'b1);
    wait_done();
    check_writes(1);
    chk("fresh_checksum", {24'd0, checksum}, {24'd0, model_csum()});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
